// File: rtl/hc595_frame_ctrl.sv
// Serializes {seg,sel} MSB-first into two cascaded 74HC595s, then latches; done 33*CLK_DIV+1 cycles after accept.
// in_ready only in IDLE (back-to-back on the done cycle); SKIP_DUP_EN drops frames equal to the last latched one.
module hc595_frame_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int DIV_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sel,
  input  logic [7:0] in_seg,
  output logic       sh_cp,
  output logic       st_cp,
  output logic       ds,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [15:0]      sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sh_cp_q, sh_cp_d;
  logic             st_cp_q, st_cp_d;
  logic             ds_q, ds_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      word;
  logic             div_end;
`ifdef SKIP_DUP_EN
  logic [15:0]      last_word_q, last_word_d;
  logic             last_vld_q, last_vld_d;
`endif

  assign word    = {in_seg, in_sel};
  assign div_end = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      sh_cp_q    <= 1'b0;
      st_cp_q    <= 1'b0;
      ds_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
`ifdef SKIP_DUP_EN
      last_word_q <= '0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      sh_cp_q    <= sh_cp_d;
      st_cp_q    <= st_cp_d;
      ds_q       <= ds_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
`ifdef SKIP_DUP_EN
      last_word_q <= last_word_d;
      last_vld_q  <= last_vld_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sh_cp_d   = sh_cp_q;
    st_cp_d   = st_cp_q;
    ds_d      = ds_q;
    done_d    = 1'b0;
`ifdef SKIP_DUP_EN
    last_word_d = last_word_q;
    last_vld_d  = last_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
`ifdef SKIP_DUP_EN
          if (last_vld_q && (word == last_word_q)) begin
            done_d = 1'b1;
          end else
`endif
          begin
            sr_d      = word;
            ds_d      = word[15];
            bit_cnt_d = 4'd0;
            div_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (!div_end) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
          div_cnt_d = '0;
          if (!sh_cp_q) begin
            sh_cp_d = 1'b1;
          end else if (bit_cnt_q == 4'd15) begin
            sh_cp_d = 1'b0;
            st_cp_d = 1'b1;
            state_d = LATCH;
`ifdef SKIP_DUP_EN
            // The register rotates, so one more rotation restores the original word.
            last_word_d = {sr_q[14:0], sr_q[15]};
            last_vld_d  = 1'b1;
`endif
          end else begin
            sh_cp_d   = 1'b0;
            sr_d      = {sr_q[14:0], sr_q[15]};
            ds_d      = sr_q[14];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      LATCH: begin
        if (!div_end) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
          div_cnt_d = '0;
          st_cp_d   = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  assign sh_cp    = sh_cp_q;
  assign st_cp    = st_cp_q;
  assign ds       = ds_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_hc595_frame_ctrl.sv
// Directed bench: one instance at CLK_DIV=1, one at CLK_DIV=4, sharing clock and reset.
module tb_hc595_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v1 = 1'b0, v4 = 1'b0;
  logic [7:0] sel1 = 8'h00, seg1 = 8'h00, sel4 = 8'h00, seg4 = 8'h00;
  logic       rdy1, sh1, st1, ds1, busy1, done1;
  logic       rdy4, sh4, st4, ds4, busy4, done4;

  int checks = 0;
  int failures = 0;

  int          sh1_cnt = 0, st1_cnt = 0, sh4_cnt = 0, st4_cnt = 0;
  logic [31:0] cap1 = '0, cap4 = '0;
  int          sh_base, st_base;

  always #5 clk = ~clk;

  hc595_frame_ctrl #(.CLK_DIV(1), .DIV_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_sel(sel1), .in_seg(seg1),
    .sh_cp(sh1), .st_cp(st1), .ds(ds1), .busy(busy1), .done(done1)
  );

  hc595_frame_ctrl #(.CLK_DIV(4), .DIV_W(8)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_sel(sel4), .in_seg(seg4),
    .sh_cp(sh4), .st_cp(st4), .ds(ds4), .busy(busy4), .done(done4)
  );

  always @(posedge sh1) begin sh1_cnt++; cap1 = {cap1[30:0], ds1}; end
  always @(posedge st1) st1_cnt++;
  always @(posedge sh4) begin sh4_cnt++; cap4 = {cap4[30:0], ds4}; end
  always @(posedge st4) st4_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle1(input string tag, input logic rdy_exp);
    check1({tag, "_sh"}, sh1, 1'b0);
    check1({tag, "_st"}, st1, 1'b0);
    check1({tag, "_ds"}, ds1, 1'b0);
    check1({tag, "_done"}, done1, 1'b0);
    check1({tag, "_busy"}, busy1, 1'b0);
    check1({tag, "_rdy"}, rdy1, rdy_exp);
  endtask

  initial begin
    // Reset: two cycles high, then idle outputs with in_ready raised.
    ticks(2);
    rst = 1'b0;
    tick();
    check_idle1("reset", 1'b1);
    check1("reset_rdy4", rdy4, 1'b1);
    check1("reset_busy4", busy4, 1'b0);

    // Single frame FE/C0 at CLK_DIV=1.
    sh_base = sh1_cnt; st_base = st1_cnt;
    sel1 = 8'hFE; seg1 = 8'hC0; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check1("single_busy_c1", busy1, 1'b1);
    check1("single_rdy_c1", rdy1, 1'b0);
    ticks(32);
    check1("single_st_c33", st1, 1'b1);
    check1("single_done_c33", done1, 1'b0);
    tick();
    check1("single_done_c34", done1, 1'b1);
    check1("single_st_c34", st1, 1'b0);
    check1("single_rdy_c34", rdy1, 1'b1);
    check32("single_bits", {16'h0, cap1[15:0]}, 32'h0000C0FE);
    check32("single_sh_rises", sh1_cnt - sh_base, 32'd16);
    check32("single_st_rises", st1_cnt - st_base, 32'd1);
    tick();
    check1("single_done_c35", done1, 1'b0);

    // Back-to-back with in_valid held through the first frame.
    sh_base = sh1_cnt; st_base = st1_cnt;
    sel1 = 8'h12; seg1 = 8'h34; v1 = 1'b1;
    tick();
    sel1 = 8'h56; seg1 = 8'h78;
    ticks(33);
    check1("b2b_done1", done1, 1'b1);
    check1("b2b_rdy_at_done1", rdy1, 1'b1);
    tick();
    check1("b2b_busy_f2", busy1, 1'b1);
    check1("b2b_done_f2_c1", done1, 1'b0);
    ticks(33);
    check1("b2b_done2", done1, 1'b1);
    v1 = 1'b0;
    check32("b2b_bits", cap1, 32'h34127856);
    check32("b2b_sh_rises", sh1_cnt - sh_base, 32'd32);
    check32("b2b_st_rises", st1_cnt - st_base, 32'd2);
    tick();
    check1("b2b_no_third_busy", busy1, 1'b0);
    check1("b2b_rdy_after", rdy1, 1'b1);

    // Reset after the seventh shift-clock rise.
    sh_base = sh1_cnt; st_base = st1_cnt;
    sel1 = 8'hAB; seg1 = 8'hCD; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 40 && (sh1_cnt - sh_base) < 7; i++) tick();
    check32("midrst_seventh_rise", sh1_cnt - sh_base, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle1("midrst", 1'b0);
    check32("midrst_no_st", st1_cnt - st_base, 32'd0);
    tick();
    check1("midrst_rdy_back", rdy1, 1'b1);
    sh_base = sh1_cnt; st_base = st1_cnt;
    sel1 = 8'h01; seg1 = 8'hFF; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    ticks(33);
    check1("post_rst_done", done1, 1'b1);
    check32("post_rst_bits", {16'h0, cap1[15:0]}, 32'h0000FF01);
    check32("post_rst_sh_rises", sh1_cnt - sh_base, 32'd16);
    check32("post_rst_st_rises", st1_cnt - st_base, 32'd1);

    // Divider at CLK_DIV=4: AA/55.
    sh_base = sh4_cnt; st_base = st4_cnt;
    sel4 = 8'hAA; seg4 = 8'h55; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    for (int c = 1; c <= 134; c++) begin
      if (c > 1) tick();
      if (c == 1) check1("div_sh_c1", sh4, 1'b0);
      if (c == 4) check1("div_sh_c4", sh4, 1'b0);
      if (c == 5) check1("div_sh_c5", sh4, 1'b1);
      if (c == 8) check1("div_sh_c8", sh4, 1'b1);
      if (c == 9) check1("div_sh_c9", sh4, 1'b0);
      if (c == 128) check1("div_sh_c128", sh4, 1'b1);
      if (c == 128) check1("div_st_c128", st4, 1'b0);
      if (c == 129) check1("div_st_c129", st4, 1'b1);
      if (c == 132) check1("div_st_c132", st4, 1'b1);
      if (c == 132) check1("div_done_c132", done4, 1'b0);
      if (c == 133) check1("div_done_c133", done4, 1'b1);
      if (c == 133) check1("div_st_c133", st4, 1'b0);
      if (c == 134) check1("div_done_c134", done4, 1'b0);
    end
    check32("div_bits", {16'h0, cap4[15:0]}, 32'h000055AA);
    check32("div_sh_rises", sh4_cnt - sh_base, 32'd16);
    check32("div_st_rises", st4_cnt - st_base, 32'd1);

`ifdef SKIP_DUP_EN
    // Duplicate suppression: second identical frame completes without shifting.
    sh_base = sh1_cnt; st_base = st1_cnt;
    sel1 = 8'h7F; seg1 = 8'h3F; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    ticks(33);
    check1("dup_first_done", done1, 1'b1);
    tick();
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check1("dup_skip_done", done1, 1'b1);
    check1("dup_skip_busy", busy1, 1'b0);
    check1("dup_skip_rdy", rdy1, 1'b1);
    ticks(5);
    check32("dup_sh_rises", sh1_cnt - sh_base, 32'd16);
    check32("dup_st_rises", st1_cnt - st_base, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    sh_base = sh1_cnt;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check1("dup_after_rst_busy", busy1, 1'b1);
    ticks(33);
    check1("dup_after_rst_done", done1, 1'b1);
    check32("dup_after_rst_sh", sh1_cnt - sh_base, 32'd16);
    check32("dup_after_rst_bits", {16'h0, cap1[15:0]}, 32'h00003F7F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
